// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants for the stopwatch datapath: the default clock divider and
// debounce lengths, plus the counter widths derived from them, so the input
// front end, the counter and the display stages all size their counters the
// same way.
// Ports: none (package).

package stopwatch_pkg;

    localparam int unsigned DIV_DEF        = 100_000_000;  // clk cycles per second
    localparam int unsigned DEB_CYCLES_DEF = 1_000_000;    // stable cycles to accept a change

    // Bits needed for a counter spanning 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DIV_W = cnt_width(DIV_DEF);
    localparam int unsigned DEB_W = cnt_width(DEB_CYCLES_DEF);

endpackage

// File: rtl/stopwatch_input_front_sync_debounce.sv
// sync_debounce
// Two-flop synchronizer followed by a counting debouncer for one raw,
// asynchronous, bouncy input. A new value is accepted only after it has been
// seen on the synchronized signal for DEB_CYCLES consecutive cycles.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   raw    in   raw button/switch level
//   level  out  debounced level
//   rise   out  registered one-cycle pulse, high in the first cycle level is 1

module sync_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic          rise_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that matches the stable value restarts qualification, so a
    // bounce shorter than DEB_CYCLES never gets through.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= stable_d & ~stable_q;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_input_front.sv
// stopwatch_input_front
// Conditions the raw board controls for the stopwatch counter: debounces the
// buttons and switches, turns the pause button into a toggled pause level and
// the clear button into a one-cycle clear pulse, and derives the 1 Hz / 2 Hz
// count enable and the 1 Hz blink from the system clock.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   btn_rst  in   raw clear button
//   btn_pse  in   raw pause button
//   sw_sel   in   raw select switch (1 = seconds field)
//   sw_adj   in   raw adjust-mode switch
//   sel      out  debounced select level
//   adj      out  debounced adjust level
//   pse      out  pause level, toggled per pause press
//   clr      out  one-cycle clear pulse per clear press
//   cnt_en   out  one-cycle count enable
//   blink    out  1 Hz square wave, high during the first half of each second

module stopwatch_input_front
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV        = DIV_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_rst,
    input  logic btn_pse,
    input  logic sw_sel,
    input  logic sw_adj,
    output logic sel,
    output logic adj,
    output logic pse,
    output logic clr,
    output logic cnt_en,
    output logic blink
);

    localparam int unsigned   DW        = cnt_width(DIV);
    localparam logic [DW-1:0] LAST      = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);
    localparam logic [DW-1:0] HALF      = DW'(DIV / 2);

    logic clr_lvl, clr_rise;
    logic pse_lvl, pse_rise;
    logic sel_rise, adj_rise;
    logic unused_lvl;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_rst),
        .level (clr_lvl),
        .rise  (clr_rise)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pse_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_pse),
        .level (pse_lvl),
        .rise  (pse_rise)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel_sw (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_sel),
        .level (sel),
        .rise  (sel_rise)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_adj_sw (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_adj),
        .level (adj),
        .rise  (adj_rise)
    );

    // Button releases and switch edges carry no meaning here.
    assign unused_lvl = ^{clr_lvl, pse_lvl, sel_rise, adj_rise};

    logic          run_q;
    logic [DW-1:0] div_q, div_d;
    logic          tick_1, tick_2, tick_sel;
    logic          pse_q, clr_q, cnt_en_q, blink_q;

    assign tick_1   = (div_q == LAST);
    assign tick_2   = tick_1 | (div_q == HALF_LAST);
    assign tick_sel = adj ? tick_2 : tick_1;

    // The divider holds for the edge on which reset is released, so the first
    // second is counted from the first fully running clock edge. A clear
    // restarts the second so the next count is a full period away.
    always_comb begin
        div_d = div_q;
        if (clr_rise) begin
            div_d = '0;
        end else if (run_q) begin
            div_d = tick_1 ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            pse_q    <= 1'b0;
            clr_q    <= 1'b0;
            cnt_en_q <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            div_q    <= div_d;
            // Gating uses the pre-toggle pause level, so a press landing on a
            // tick still lets that tick through.
            pse_q    <= pse_q ^ pse_rise;
            clr_q    <= clr_rise;
            cnt_en_q <= tick_sel & ~pse_q & ~clr_rise;
            blink_q  <= run_q & (div_q < HALF);
        end
    end

    assign pse    = pse_q;
    assign clr    = clr_q;
    assign cnt_en = cnt_en_q;
    assign blink  = blink_q;

endmodule

// File: doc/stopwatch_input_front.md
# stopwatch_input_front

Front-end conditioning stage that sits directly upstream of the stopwatch counter. It synchronizes and debounces the raw board buttons and switches, turns the pause button into a toggled pause level and the reset button into a one-cycle clear pulse, and derives the 1 Hz / 2 Hz count enables from the system clock. The counter then runs entirely on clean, single-cycle, registered controls.

## Interface
Parameters:
- DIV, 100_000_000: clock cycles per second; must be even and ≥ 4.
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button or switch change; ≥ 2.

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  asynchronous, active-high reset
- btn_rst  in  1  raw clear button, asynchronous, bouncy
- btn_pse  in  1  raw pause button, asynchronous, bouncy
- sw_sel  in  1  raw select switch (1 = seconds field)
- sw_adj  in  1  raw adjust-mode switch
- sel  out  1  debounced select level
- adj  out  1  debounced adjust level
- pse  out  1  pause level, toggled per pause press
- clr  out  1  one-cycle clear pulse per clear press
- cnt_en  out  1  one-cycle count enable for the counter
- blink  out  1  1 Hz square wave, high during first half of each second

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: holds the stable value and a counter. If the synchronized value equals stable, the counter is cleared. Otherwise the counter increments. When the counter reaches DEB_CYCLES-1 while still different, stable takes the new value and the counter clears.
- Rise detector on stable btn_rst gives clr (one cycle). Rise detector on stable btn_pse toggles pse. Releases do nothing.
- sel = stable sw_sel. adj = stable sw_adj.
- Divider div_cnt counts 0..DIV-1 and wraps.
  - tick_1 fires when div_cnt == DIV-1.
  - tick_2 fires when div_cnt == DIV/2-1 or DIV-1.
- Selected tick: tick_2 when adj = 1, else tick_1.
- cnt_en (registered) = selected tick & ~pse & ~clr_event, evaluated on current register values.
- blink (registered) = (div_cnt < DIV/2).
- Clear event: div_cnt restarts at 0, so the first second after a clear is full length. cnt_en is suppressed in the clear cycle. pse is not changed by a clear.
- Simultaneous events:
  - Pause press and tick in the same cycle: the tick is gated by the pre-toggle pse.
  - Clear and pause press in the same cycle: both take effect.

## Timing
- Reset (asynchronous): all outputs 0; synchronizers, stable values, debounce counters and div_cnt are 0.
- Raw edge to stable change: 2 cycles of synchronization, then DEB_CYCLES cycles.
- Raw button press (held clean) to clr/pse change: exactly DEB_CYCLES+3 rising clk edges.
- Raw switch change to sel/adj change: DEB_CYCLES+2 edges.
- A bounce shorter than DEB_CYCLES restarts qualification and produces no output.
- cnt_en is high one cycle after the tick condition.
  - Period is DIV cycles when adj = 0, DIV/2 cycles when adj = 1, with no drift across mode changes.
- Holding a button produces exactly one clr pulse or one pse toggle.
- Reset asserted mid-debounce or mid-second discards all progress. The first cnt_en after reset release occurs at edge DIV+1.

## Structure
- Shared package stopwatch_pkg holds the DIV and DEB_CYCLES defaults and the derived counter widths ($clog2), for reuse by the counter and the display stages.
- One natural sub-module, sync_debounce: synchronizer + debouncer + registered rise pulse, parameterized by DEB_CYCLES, with outputs level and rise. It is instantiated four times.

## Test plan
Benches use DIV=8 and DEB_CYCLES=4.
- Reset, then idle: cnt_en pulses at edges 9, 17, 25. blink is high for 4 cycles and low for 4. All other outputs stay 0.
- btn_pse: clean press held for 20 cycles.
  - pse rises exactly 7 edges after the raw rise.
  - No cnt_en while paused.
  - A second press toggles pse back to 0 and cnt_en resumes.
- Press btn_rst with 3-cycle bounce pulses first, then hold clean.
  - Required: exactly one clr pulse, 7 edges after the final clean rise.
  - div_cnt restarts, so the next cnt_en comes 8 cycles after clr.
- Set sw_adj=1: after 6 edges adj=1, then cnt_en arrives every 4 cycles. Returning to adj=0 restores the 8-cycle period, aligned to the original phase.
- Pause press debounces into the same cycle as a tick: cnt_en is still issued for that tick and pse=1 from the next cycle. Clear landing on a tick cycle: no cnt_en.
- Assert rst mid-debounce (counter = 2) and mid-second: all outputs return to 0 immediately. After release, the first cnt_en is at edge 9.
